// File: rtl/dm_be_if.sv
// Load/store bus between the MEM-stage controls and the data memory.
interface dm_be_if;
    logic [31:0] memaddr;
    logic [31:0] memdata;
    logic        memread;
    logic        memwrite;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] memout;
    logic        busy;
    logic        addr_err;
    logic        err_valid;
    logic [31:0] err_addr;

    modport master (
        output memaddr, memdata, memread, memwrite, size, sign_ext,
        input  memout, busy, addr_err, err_valid, err_addr
    );

    modport slave (
        input  memaddr, memdata, memread, memwrite, size, sign_ext,
        output memout, busy, addr_err, err_valid, err_addr
    );
endinterface

// File: rtl/dm_be.sv
// Byte-addressable data memory with lane-masked stores, extended sub-word
// loads, sticky misalignment capture and a post-reset clear engine.
module dm_be #(
    parameter int unsigned AW = 10
) (
    input  logic     clk,
    input  logic     reset,
    dm_be_if.slave   bus
);
    localparam int unsigned DEPTH = 2**AW;

    typedef enum logic {CLEAR, READY} state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] ptr;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          access;
    logic          misalign;
    logic          addr_err;
    logic          busy;
    logic          clear_we;
    logic          store_we;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   wmask;
    logic [31:0]   rdword;
    logic [31:0]   rdshift;
    logic [31:0]   ldata;
    logic          err_valid;
    logic [31:0]   err_addr;
    logic          unused_addr_hi;

    assign idx            = bus.memaddr[AW+1:2];
    assign lane           = bus.memaddr[1:0];
    assign access         = bus.memread | bus.memwrite;
    assign unused_addr_hi = ^bus.memaddr[31:AW+2];

    // Alignment and legal-size check for the current access
    always_comb begin
        misalign = 1'b0;
        unique case (bus.size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = lane[0];
            2'b10:   misalign = |lane;
            default: misalign = 1'b1;
        endcase
        addr_err = access & misalign;
    end

    // Clear-engine state register
    always_ff @(posedge clk) begin
        state <= state_nx;
    end

    // Clear-engine next state: reset restarts, last word finishes
    always_comb begin
        state_nx = state;
        if (reset) begin
            state_nx = CLEAR;
        end else if (state == CLEAR && ptr == AW'(DEPTH - 1)) begin
            state_nx = READY;
        end
    end

    // Clear-engine outputs and write qualifiers
    always_comb begin
        busy     = (state == CLEAR);
        clear_we = busy & ~reset;
        store_we = bus.memwrite & ~busy & ~addr_err & ~reset;
    end

    // Clear pointer walks the array one word per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (clear_we) begin
            ptr <= ptr + AW'(1);
        end
    end

    // Byte-lane enables and replicated store data
    always_comb begin
        be    = 4'b0000;
        wdata = bus.memdata;
        unique case (bus.size)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{bus.memdata[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.memdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{be[i]}};
        end
    end

    // Array writes: masked store, then clear (clear wins on same word)
    always_ff @(posedge clk) begin
        if (store_we) begin
            mem[idx] <= (mem[idx] & ~wmask) | (wdata & wmask);
        end
        if (clear_we) begin
            mem[ptr] <= '0;
        end
    end

    // Combinational load with lane select and extension
    always_comb begin
        rdword  = mem[idx];
        rdshift = rdword >> {lane, 3'b000};
        ldata   = rdword;
        unique case (bus.size)
            2'b00:   ldata = bus.sign_ext ? {{24{rdshift[7]}}, rdshift[7:0]}
                                          : {24'h0, rdshift[7:0]};
            2'b01:   ldata = bus.sign_ext ? {{16{rdshift[15]}}, rdshift[15:0]}
                                          : {16'h0, rdshift[15:0]};
            default: ldata = rdword;
        endcase
        if (!(bus.memread && !busy && !addr_err)) begin
            ldata = '0;
        end
    end

    // Sticky capture of the first faulting address
    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (addr_err && !err_valid) begin
            err_valid <= 1'b1;
            err_addr  <= bus.memaddr;
        end
    end

    assign bus.memout    = ldata;
    assign bus.busy      = busy;
    assign bus.addr_err  = addr_err;
    assign bus.err_valid = err_valid;
    assign bus.err_addr  = err_addr;
endmodule

// File: tb/tb_dm_be.sv
// Scoreboard bench for dm_be with a 16-word array.
module tb_dm_be;
    localparam int K_MEMOUT = 0;
    localparam int K_BUSY   = 1;
    localparam int K_AERR   = 2;
    localparam int K_EVALID = 3;
    localparam int K_EADDR  = 4;

    typedef struct {
        int unsigned cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        q[$];

    dm_be_if bus();

    dm_be #(.AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation due this cycle and compare
    exp_t        e;
    logic [31:0] act;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            case (e.kind)
                K_MEMOUT: act = bus.memout;
                K_BUSY:   act = {31'b0, bus.busy};
                K_AERR:   act = {31'b0, bus.addr_err};
                K_EVALID: act = {31'b0, bus.err_valid};
                default:  act = bus.err_addr;
            endcase
            n_chk++;
            if (e.cyc != cyc || act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (cycle %0d due %0d)",
                         e.name, act, e.val, cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int k, input logic [31:0] v, input string nm);
        exp_t x;
        x.cyc  = cyc;
        x.kind = k;
        x.val  = v;
        x.name = nm;
        q.push_back(x);
    endtask

    task automatic idle();
        bus.memaddr  = '0;
        bus.memdata  = '0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.size     = 2'b10;
        bus.sign_ext = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bus.memaddr  = a;
        bus.memdata  = d;
        bus.size     = sz;
        bus.memwrite = 1'b1;
        step();
        idle();
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                        input logic [31:0] exp_v, input string nm);
        bus.memaddr  = a;
        bus.size     = sz;
        bus.sign_ext = sx;
        bus.memread  = 1'b1;
        expect_v(K_MEMOUT, exp_v, nm);
        step();
        idle();
    endtask

    // Reset for one edge, then expect busy for exactly 16 edges
    task automatic reset_clear(input string nm);
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_v(K_BUSY, 32'd1, {nm, "_busy_at_reset"});
        expect_v(K_EVALID, 32'd0, {nm, "_err_valid_reset"});
        expect_v(K_EADDR, 32'd0, {nm, "_err_addr_reset"});
        expect_v(K_MEMOUT, 32'd0, {nm, "_memout_reset"});
        for (int i = 1; i <= 16; i++) begin
            step();
            expect_v(K_BUSY, (i < 16) ? 32'd1 : 32'd0, $sformatf("%s_busy_edge%0d", nm, i));
        end
    endtask

    initial begin
        idle();
        step();
        reset_clear("init");
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL init_ready_direct: busy=%b", bus.busy);
        end

        // Clear engine wipes a preloaded word
        store(32'h14, 32'hDEADBEEF, 2'b10);
        load(32'h14, 2'b10, 1'b0, 32'hDEADBEEF, "preload_w5");
        reset_clear("clr");
        load(32'h14, 2'b10, 1'b0, 32'h0, "w5_cleared");

        // Byte lanes
        store(32'h10, 32'hAABBCCDD, 2'b10);
        store(32'h12, 32'h00000011, 2'b00);
        load(32'h10, 2'b10, 1'b0, 32'hAA11CCDD, "lw_after_sb");
        load(32'h13, 2'b00, 1'b1, 32'hFFFFFFAA, "lb_0x13");
        load(32'h13, 2'b00, 1'b0, 32'h000000AA, "lbu_0x13");
        load(32'h10, 2'b00, 1'b1, 32'hFFFFFFDD, "lb_0x10");

        // Halfwords
        store(32'h22, 32'h00008001, 2'b01);
        load(32'h22, 2'b01, 1'b1, 32'hFFFF8001, "lh_0x22");
        load(32'h22, 2'b01, 1'b0, 32'h00008001, "lhu_0x22");
        load(32'h20, 2'b10, 1'b0, 32'h80010000, "lw_0x20");
        load(32'h20, 2'b01, 1'b1, 32'h00000000, "lh_0x20");

        // Misalignment and sticky fault
        bus.memaddr = 32'h31;
        bus.size    = 2'b10;
        expect_v(K_AERR, 32'd0, "no_err_without_strobe");
        step();
        bus.memaddr  = 32'h31;
        bus.memdata  = 32'hFFFFFFFF;
        bus.size     = 2'b10;
        bus.memwrite = 1'b1;
        expect_v(K_AERR, 32'd1, "aerr_sw_0x31");
        expect_v(K_EVALID, 32'd0, "err_valid_before");
        step();
        idle();
        n_chk++;
        if (bus.err_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL err_valid_direct: got %b", bus.err_valid);
        end
        n_chk++;
        if (bus.err_addr !== 32'h31) begin
            n_fail++;
            $display("FAIL err_addr_direct: got %h", bus.err_addr);
        end
        expect_v(K_EVALID, 32'd1, "err_valid_set");
        expect_v(K_EADDR, 32'h31, "err_addr_0x31");
        bus.memaddr = 32'h43;
        bus.size    = 2'b01;
        bus.memread = 1'b1;
        expect_v(K_AERR, 32'd1, "aerr_lh_0x43");
        expect_v(K_MEMOUT, 32'd0, "memout_on_fault");
        step();
        idle();
        n_chk++;
        if (bus.err_addr !== 32'h31 || bus.err_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL err_kept_direct: valid=%b addr=%h", bus.err_valid, bus.err_addr);
        end
        expect_v(K_EADDR, 32'h31, "err_addr_kept");
        expect_v(K_EVALID, 32'd1, "err_valid_kept");
        bus.memaddr = 32'h30;
        bus.size    = 2'b11;
        bus.memread = 1'b1;
        expect_v(K_AERR, 32'd1, "aerr_size11");
        expect_v(K_MEMOUT, 32'd0, "memout_size11");
        step();
        idle();
        load(32'h30, 2'b10, 1'b0, 32'h0, "faulting_store_dropped");
        reset_clear("fault");
        n_chk++;
        if (bus.busy !== 1'b0 || bus.err_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_reset_direct: busy=%b err_valid=%b", bus.busy, bus.err_valid);
        end

        // Store while busy, then restart the clear at ptr=7
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            expect_v(K_BUSY, 32'd1, $sformatf("pre_restart_busy%0d", i));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_v(K_BUSY, 32'd1, "restart_busy");
        for (int i = 1; i <= 16; i++) begin
            if (i == 6) begin
                bus.memaddr  = 32'h0;
                bus.memdata  = 32'hCAFEF00D;
                bus.size     = 2'b10;
                bus.memwrite = 1'b1;
                bus.memread  = 1'b1;
                expect_v(K_MEMOUT, 32'd0, "load_while_busy");
            end
            step();
            idle();
            expect_v(K_BUSY, (i < 16) ? 32'd1 : 32'd0, $sformatf("restart_busy_edge%0d", i));
        end
        load(32'h0, 2'b10, 1'b0, 32'h0, "busy_store_dropped");

        // Address wrap and read-during-write
        store(32'h40, 32'h5A5AA5A5, 2'b10);
        load(32'h00, 2'b10, 1'b0, 32'h5A5AA5A5, "wrap_0x40_to_0x00");
        bus.memaddr  = 32'h04;
        bus.memdata  = 32'h11112222;
        bus.size     = 2'b10;
        bus.memwrite = 1'b1;
        bus.memread  = 1'b1;
        expect_v(K_MEMOUT, 32'h0, "rdw_old_value");
        step();
        idle();
        load(32'h04, 2'b10, 1'b0, 32'h11112222, "rdw_new_value");
        load(32'h44, 2'b10, 1'b0, 32'h11112222, "wrap_read_0x44");

        step();
        step();
        while (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s: not compared, expected %h", e.name, e.val);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
